shift_cmd_seq: RTL and testbench



---
 rtl/shift_cmd_seq.sv | 175 +++++++++++++++++
 tb/tb_shift_cmd_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_seq.sv
// Command sequencer feeding the 8-bit shift register: buffers {op, din, cnt}
// commands in a small FIFO and replays each op for max(cnt,1) consecutive cycles.
module shift_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [7:0]                 cmd_din,
    input  logic [CNT_W-1:0]           cmd_cnt,
    output logic [2:0]                 op_out,
    output logic [7:0]                 din_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [2:0]        mem_op_q  [DEPTH];
    logic [7:0]        mem_din_q [DEPTH];
    logic [CNT_W-1:0]  mem_cnt_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  count_q;
    logic [LVL_W-1:0]  count_d;

    state_t            state_q;
    logic [CNT_W-1:0]  remain_q;
    logic [2:0]        op_out_q;
    logic [7:0]        din_out_q;
    logic              busy_q;
    logic              done_q;

    logic              empty_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic              last_s;
    logic [2:0]        head_op_s;
    logic [7:0]        head_din_s;
    logic [CNT_W-1:0]  head_rem_s;

    // FIFO status, handshake and head-of-queue decode
    always_comb begin
        empty_s    = (count_q == {LVL_W{1'b0}});
        full_s     = (count_q == FULL_LVL);
        push_s     = cmd_valid && !full_s;
        last_s     = (remain_q == {CNT_W{1'b0}});
        pop_s      = !empty_s && ((state_q == ST_IDLE) || ((state_q == ST_RUN) && last_s));
        head_op_s  = mem_op_q[rd_ptr_q];
        head_din_s = mem_din_q[rd_ptr_q];
        if (mem_cnt_q[rd_ptr_q] == {CNT_W{1'b0}}) begin
            head_rem_s = {CNT_W{1'b0}};
        end else begin
            head_rem_s = mem_cnt_q[rd_ptr_q] - CNT_W'(1);
        end
    end

    // Occupancy next state; a simultaneous push and pop leaves it unchanged
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until the pointers cover them
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_op_q[wr_ptr_q]  <= cmd_op;
            mem_din_q[wr_ptr_q] <= cmd_din;
            mem_cnt_q[wr_ptr_q] <= cmd_cnt;
        end
    end

    // Issue FSM with registered outputs; done is set together with the last issue cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            remain_q  <= {CNT_W{1'b0}};
            op_out_q  <= 3'b000;
            din_out_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_q   <= ST_RUN;
                        remain_q  <= head_rem_s;
                        op_out_q  <= head_op_s;
                        din_out_q <= head_din_s;
                        busy_q    <= 1'b1;
                        done_q    <= (head_rem_s == {CNT_W{1'b0}});
                    end else begin
                        state_q   <= ST_IDLE;
                        remain_q  <= {CNT_W{1'b0}};
                        op_out_q  <= 3'b000;
                        din_out_q <= 8'h00;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!last_s) begin
                        state_q  <= ST_RUN;
                        remain_q <= remain_q - CNT_W'(1);
                        busy_q   <= 1'b1;
                        done_q   <= (remain_q == CNT_W'(1));
                    end else if (pop_s) begin
                        state_q   <= ST_RUN;
                        remain_q  <= head_rem_s;
                        op_out_q  <= head_op_s;
                        din_out_q <= head_din_s;
                        busy_q    <= 1'b1;
                        done_q    <= (head_rem_s == {CNT_W{1'b0}});
                    end else begin
                        state_q   <= ST_IDLE;
                        remain_q  <= {CNT_W{1'b0}};
                        op_out_q  <= 3'b000;
                        din_out_q <= 8'h00;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    remain_q  <= {CNT_W{1'b0}};
                    op_out_q  <= 3'b000;
                    din_out_q <= 8'h00;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = !full_s;
    assign op_out    = op_out_q;
    assign din_out   = din_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign level     = count_q;

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Directed self-checking bench for shift_cmd_seq with hand-computed cycle-by-cycle expectations.
module tb_shift_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_din;
    logic [3:0] cmd_cnt;
    logic [2:0] op_out;
    logic [7:0] din_out;
    logic       busy;
    logic       done;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    shift_cmd_seq #(.DEPTH(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_din   (cmd_din),
        .cmd_cnt   (cmd_cnt),
        .op_out    (op_out),
        .din_out   (din_out),
        .busy      (busy),
        .done      (done),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command across exactly one rising edge.
    task automatic push_cmd(input logic [2:0] op, input logic [7:0] din, input logic [3:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_din   = din;
        cmd_cnt   = cnt;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'b000;
        cmd_din = 8'h00;
        cmd_cnt = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({op_out, din_out, busy, done, level, cmd_ready} !== {3'b000, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got op=%b din=%h busy=%b done=%b level=%0d ready=%b want 000/00/0/0/0/1",
                     op_out, din_out, busy, done, level, cmd_ready);
        end
    endtask

    task automatic test_single();
        push_cmd(3'b001, 8'hA5, 4'd1);
        checks++;
        if ({op_out, busy, level} !== {3'b000, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL single_latency got op=%b busy=%b level=%0d want 000/0/1", op_out, busy, level);
        end
        tick();
        checks++;
        if ({op_out, din_out, busy, done, level} !== {3'b001, 8'hA5, 1'b1, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL single_issue got op=%b din=%h busy=%b done=%b level=%0d want 001/a5/1/1/0",
                     op_out, din_out, busy, done, level);
        end
        tick();
        checks++;
        if ({op_out, din_out, busy, done} !== {3'b000, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_after got op=%b din=%h busy=%b done=%b want 000/00/0/0", op_out, din_out, busy, done);
        end
    endtask

    task automatic test_repeat();
        logic [2:0] exp_done;
        exp_done = 3'b100;
        push_cmd(3'b010, 8'h3C, 4'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({op_out, din_out, busy, done} !== {3'b010, 8'h3C, 1'b1, exp_done[i]}) begin
                errors++;
                $display("FAIL repeat_cyc%0d got op=%b din=%h busy=%b done=%b want 010/3c/1/%b",
                         i, op_out, din_out, busy, done, exp_done[i]);
            end
        end
        tick();
        checks++;
        if ({op_out, busy, done} !== {3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL repeat_after got op=%b busy=%b done=%b want 000/0/0", op_out, busy, done);
        end
    endtask

    task automatic test_cnt_zero();
        push_cmd(3'b111, 8'h5A, 4'd0);
        tick();
        checks++;
        if ({op_out, din_out, busy, done} !== {3'b111, 8'h5A, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL cnt0_issue got op=%b din=%h busy=%b done=%b want 111/5a/1/1", op_out, din_out, busy, done);
        end
        tick();
        checks++;
        if ({op_out, busy, done} !== {3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL cnt0_after got op=%b busy=%b done=%b want 000/0/0", op_out, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        push_cmd(3'b001, 8'h81, 4'd1);
        push_cmd(3'b100, 8'hF0, 4'd2);
        checks++;
        if ({op_out, din_out, busy, done, level} !== {3'b001, 8'h81, 1'b1, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL b2b_cyc1 got op=%b din=%h busy=%b done=%b level=%0d want 001/81/1/1/1",
                     op_out, din_out, busy, done, level);
        end
        push_cmd(3'b110, 8'h0F, 4'd1);
        checks++;
        if ({op_out, din_out, busy, done, level} !== {3'b100, 8'hF0, 1'b1, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL b2b_cyc2 got op=%b din=%h busy=%b done=%b level=%0d want 100/f0/1/0/1",
                     op_out, din_out, busy, done, level);
        end
        tick();
        checks++;
        if ({op_out, din_out, busy, done, level} !== {3'b100, 8'hF0, 1'b1, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL b2b_cyc3 got op=%b din=%h busy=%b done=%b level=%0d want 100/f0/1/1/1",
                     op_out, din_out, busy, done, level);
        end
        tick();
        checks++;
        if ({op_out, din_out, busy, done, level} !== {3'b110, 8'h0F, 1'b1, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL b2b_cyc4 got op=%b din=%h busy=%b done=%b level=%0d want 110/0f/1/1/0",
                     op_out, din_out, busy, done, level);
        end
        tick();
        checks++;
        if ({op_out, din_out, busy, done} !== {3'b000, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_after got op=%b din=%h busy=%b done=%b want 000/00/0/0", op_out, din_out, busy, done);
        end
    endtask

    task automatic test_full();
        logic [2:0] q_op  [4];
        logic [7:0] q_din [4];
        q_op[0] = 3'b001; q_din[0] = 8'hB1;
        q_op[1] = 3'b010; q_din[1] = 8'hC2;
        q_op[2] = 3'b101; q_din[2] = 8'hD3;
        q_op[3] = 3'b110; q_din[3] = 8'hE4;
        push_cmd(3'b011, 8'h11, 4'd15);
        tick();
        for (int i = 0; i < 4; i++) begin
            push_cmd(q_op[i], q_din[i], 4'd1);
        end
        checks++;
        if ({level, cmd_ready} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL full_level got level=%0d ready=%b want 4/0", level, cmd_ready);
        end
        push_cmd(3'b111, 8'h77, 4'd1);
        checks++;
        if ({level, cmd_ready, op_out} !== {3'd4, 1'b0, 3'b011}) begin
            errors++;
            $display("FAIL full_refuse got level=%0d ready=%b op=%b want 4/0/011", level, cmd_ready, op_out);
        end
        repeat (9) tick();
        checks++;
        if ({op_out, din_out, done, level, cmd_ready} !== {3'b011, 8'h11, 1'b1, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL full_last got op=%b din=%h done=%b level=%0d ready=%b want 011/11/1/4/0",
                     op_out, din_out, done, level, cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({op_out, din_out, done, level, cmd_ready} !== {q_op[i], q_din[i], 1'b1, 3'(3 - i), 1'b1}) begin
                errors++;
                $display("FAIL full_drain%0d got op=%b din=%h done=%b level=%0d ready=%b want %b/%h/1/%0d/1",
                         i, op_out, din_out, done, level, cmd_ready, q_op[i], q_din[i], 3 - i);
            end
        end
        tick();
        checks++;
        if ({op_out, busy, level} !== {3'b000, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL full_empty got op=%b busy=%b level=%0d want 000/0/0", op_out, busy, level);
        end
    endtask

    task automatic test_reset_mid_run();
        push_cmd(3'b100, 8'h99, 4'd5);
        push_cmd(3'b011, 8'h21, 4'd1);
        push_cmd(3'b001, 8'h22, 4'd1);
        checks++;
        if ({op_out, busy, done, level} !== {3'b100, 1'b1, 1'b0, 3'd2}) begin
            errors++;
            $display("FAIL rstrun_pre got op=%b busy=%b done=%b level=%0d want 100/1/0/2", op_out, busy, done, level);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({op_out, din_out, busy, done, level, cmd_ready} !== {3'b000, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL rstrun_flush got op=%b din=%h busy=%b done=%b level=%0d ready=%b want 000/00/0/0/0/1",
                     op_out, din_out, busy, done, level, cmd_ready);
        end
        tick();
        checks++;
        if ({op_out, busy, done} !== {3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstrun_idle got op=%b busy=%b done=%b want 000/0/0", op_out, busy, done);
        end
        push_cmd(3'b101, 8'h42, 4'd2);
        tick();
        checks++;
        if ({op_out, din_out, busy, done} !== {3'b101, 8'h42, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rstrun_new1 got op=%b din=%h busy=%b done=%b want 101/42/1/0", op_out, din_out, busy, done);
        end
        tick();
        checks++;
        if ({op_out, din_out, busy, done} !== {3'b101, 8'h42, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rstrun_new2 got op=%b din=%h busy=%b done=%b want 101/42/1/1", op_out, din_out, busy, done);
        end
        tick();
        checks++;
        if ({op_out, busy, done} !== {3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstrun_after got op=%b busy=%b done=%b want 000/0/0", op_out, busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_cnt_zero();
        test_back_to_back();
        test_full();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
